alt_trigout_reader: RTL and testbench
=====================================

Name: alt_trigout_reader

Overview:
Wishbone master that drains the alternate trigger-out timestamp FIFO through that block's slave register interface.
- Polls the status register.
- When ts_present is set, reads the seconds/mask words, then the cycles word. Reading cycles pops the FIFO entry on the slave side.
- Presents each assembled timestamp on a valid/ready output stream for downstream logic (e.g. the acquisition timetag path).

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the trigout register bank. Offsets: status +0x00, ts_mask_sec high word +0x08, ts_mask_sec low word +0x0C, ts_cycles +0x10.
POLL_INTERVAL, 256, idle cycles between status reads when the FIFO is empty (1..65535).
TIMEOUT, 1024, cycles to wait for ack/err after a request is accepted before abandoning it.

Ports:
clk_i  in  1  system clock; all logic is in this single clock domain.
rst_i  in  1  synchronous, active-high reset.
enable_i  in  1  run the poll/drain engine.
wb_cyc_o  out  1  WB cycle.
wb_stb_o  out  1  WB strobe.
wb_adr_o  out  32  WB byte address.
wb_sel_o  out  4  byte select; always 4'hF.
wb_we_o  out  1  always 0 (read-only master).
wb_dat_o  out  32  always 0.
wb_dat_i  in  32  read data.
wb_ack_i  in  1  ack.
wb_err_i  in  1  bus error.
wb_stall_i  in  1  pipelined stall.
ts_valid_o  out  1  timestamp available.
ts_ready_i  in  1  consumer accepts timestamp.
ts_sec_o  out  40  seconds: {hi[7:0], lo[31:0]}.
ts_cycles_o  out  28  cycles: cycles word [27:0].
ts_mask_o  out  5  {ext, ch4, ch3, ch2, ch1}, taken from hi word bits {24,19,18,17,16}.
ts_count_o  out  16  count of delivered timestamps; wraps at 65535 -> 0.
bus_err_o  out  1  sticky: an err response was received.
timeout_o  out  1  sticky: a transaction timed out.
busy_o  out  1  FSM not in IDLE or WAIT_POLL.

Behaviour:
- Reset values: all outputs 0; wb_sel_o = 4'hF.
- Reset asserted mid-transaction: cyc/stb drop at the next edge and the FSM returns to IDLE. No transaction is replayed.
- Bus rule: one outstanding access at a time (pipelined WB).
  - cyc and stb rise together with adr.
  - stb is held while wb_stall_i = 1 and drops the cycle after stall = 0.
  - cyc is held until ack or err, then drops the same edge.
  - The timeout counter starts when the request is accepted.
  - ack/err arriving while cyc = 0 is ignored.
- FSM states and transitions:
  - IDLE: enable_i = 1 -> RD_STATUS.
  - RD_STATUS: read +0x00.
    - ack with bit8 = 1 -> RD_HI.
    - ack with bit8 = 0 -> WAIT_POLL.
  - WAIT_POLL: count POLL_INTERVAL cycles, then -> RD_STATUS.
  - RD_HI: read +0x08, latch ts_sec_o[39:32] and ts_mask_o -> RD_LO.
  - RD_LO: read +0x0C, latch ts_sec_o[31:0] -> RD_CYC.
  - RD_CYC: read +0x10, latch ts_cycles_o -> DELIVER.
  - DELIVER: ts_valid_o = 1; hold until ts_ready_i = 1.
    - On the handshake edge: ts_count_o++, then -> RD_STATUS immediately (back-to-back drain, no poll wait).
- Output registers update only on the ack of their own read. They are stable while ts_valid_o = 1.
- No bus traffic occurs while ts_valid_o = 1 and ts_ready_i = 0.
- Bus errors and timeouts:
  - Err in any read: set bus_err_o, discard partial data, -> WAIT_POLL.
  - Timeout: set timeout_o, drop cyc, -> WAIT_POLL.
  - Err or timeout during RD_CYC loses at most one entry; it is not retried.
- enable_i deasserted:
  - In WAIT_POLL: -> IDLE at once.
  - During RD_STATUS, RD_HI or RD_LO: finish the current access, then -> IDLE. No pop has occurred, so the entry is re-read later.
  - During RD_CYC or DELIVER: complete delivery, then -> IDLE.
- Sticky flags clear only on rst_i.
- Minimum latency from status read to ts_valid_o is four bus transactions plus one cycle.

Decomposition:
- Package alt_trigout_pkg holds:
  - register offset constants: status, ts_hi, ts_lo, ts_cycles;
  - status bit index TS_PRESENT = 8;
  - mask bit positions;
  - the FSM state enum.
- Sub-module wb_single_rd: issues one pipelined read.
  - Inputs: req, adr.
  - Outputs: done, err, tout, rdata.
  - Owns the stall, ack and timeout handling.
- The top level holds the FSM, the data registers and the counters.

Test Plan:
- Status reads 0x000 three times -> exactly 3 status reads spaced POLL_INTERVAL + handshake cycles apart; ts_valid_o stays 0.
- Status 0x100, hi 0x0105_0012, lo 0xDEAD_BEEF, cycles 0x0ABC_DEF1 -> ts_sec_o = 40'h12_DEAD_BEEF, ts_mask_o = 5'b10101, ts_cycles_o = 28'hABC_DEF1, ts_count_o = 1. Address order must be 0x00, 0x08, 0x0C, 0x10.
- Slave stalls 5 cycles on each request and ts_ready_i is held 0 for 20 cycles -> stb is held through the stall; no bus activity during DELIVER; one ts_cycles read per entry.
- Three entries queued -> three deliveries back-to-back with no WAIT_POLL between them; then one empty status read followed by WAIT_POLL.
- err on RD_LO -> bus_err_o = 1, no ts_valid_o, next access is a status read after POLL_INTERVAL. A slave that never acks -> timeout_o = 1 after TIMEOUT cycles, cyc drops.
- enable_i dropped during RD_HI -> no ts_cycles read issued, FSM returns to IDLE. rst_i asserted mid-RD_CYC -> cyc/stb = 0 on the next edge and all outputs back to 0.

Source files
------------

// File: rtl/alt_trigout_reader_pkg.sv
// Shared constants and types for the alternate trigger-out FIFO reader.
package alt_trigout_pkg;

    // Register offsets inside the trigout slave bank (byte addresses).
    localparam logic [31:0] OFF_STATUS    = 32'h0000_0000;
    localparam logic [31:0] OFF_TS_HI     = 32'h0000_0008;
    localparam logic [31:0] OFF_TS_LO     = 32'h0000_000C;
    localparam logic [31:0] OFF_TS_CYCLES = 32'h0000_0010;

    // Status word: an entry is waiting in the FIFO.
    localparam int unsigned TS_PRESENT = 8;

    // Trigger mask bit positions inside the hi word.
    localparam int unsigned MASK_CH1_BIT = 16;
    localparam int unsigned MASK_CH2_BIT = 17;
    localparam int unsigned MASK_CH3_BIT = 18;
    localparam int unsigned MASK_CH4_BIT = 19;
    localparam int unsigned MASK_EXT_BIT = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STATUS,
        ST_WAIT_POLL,
        ST_RD_HI,
        ST_RD_LO,
        ST_RD_CYC,
        ST_DELIVER
    } state_t;

endpackage

// File: rtl/alt_trigout_reader_if.sv
// Wishbone master bus plus timestamp output stream of the trigout reader.
interface alt_trigout_reader_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    logic        ts_valid_o;
    logic        ts_ready_i;
    logic [39:0] ts_sec_o;
    logic [27:0] ts_cycles_o;
    logic [4:0]  ts_mask_o;

    // Reader side: drives the bus request and the timestamp stream.
    modport master (
        output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
        output ts_valid_o, ts_sec_o, ts_cycles_o, ts_mask_o,
        input  ts_ready_i
    );

    // Register-bank slave and timestamp consumer side.
    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
        input  ts_valid_o, ts_sec_o, ts_cycles_o, ts_mask_o,
        output ts_ready_i
    );

endinterface

// File: rtl/alt_trigout_reader_wb_single_rd.sv
// Single outstanding pipelined Wishbone read with stall, ack/err and timeout.
module wb_single_rd #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req,
    input  logic [31:0] adr,
    output logic        done,
    output logic        err,
    output logic        tout,
    output logic [31:0] rdata,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] wait_cnt;

    // Responses only count while a cycle is open; err wins over ack.
    assign err   = wb_cyc_o & wb_err_i;
    assign done  = wb_cyc_o & wb_ack_i & ~wb_err_i;
    assign tout  = wb_cyc_o & ~wb_stb_o & ~wb_ack_i & ~wb_err_i
                 & (wait_cnt == TW'(TIMEOUT - 1));
    assign rdata = wb_dat_i;

    // Request/acceptance/response sequencing and post-acceptance timer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_adr_o <= '0;
            wait_cnt <= '0;
        end else if (!wb_cyc_o) begin
            if (req) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_adr_o <= adr;
                wait_cnt <= '0;
            end
        end else if (wb_ack_i || wb_err_i || tout) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else if (wb_stb_o) begin
            if (!wb_stall_i) begin
                wb_stb_o <= 1'b0;
            end
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alt_trigout_reader.sv
// Polls the trigout timestamp FIFO and streams out each assembled entry.
module alt_trigout_reader
    import alt_trigout_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned POLL_INTERVAL = 256,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    alt_trigout_reader_if.master  bus,
    output logic [15:0]           ts_count_o,
    output logic                  bus_err_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    state_t      state_q, state_d;
    logic        rd_req;
    logic [31:0] rd_off;
    logic        rd_done, rd_err, rd_tout;
    logic [31:0] rd_data;
    logic [15:0] poll_cnt;
    logic [7:0]  sec_hi;
    logic [31:0] sec_lo;
    logic [27:0] cycles;
    logic [4:0]  mask;

    wb_single_rd #(.TIMEOUT(TIMEOUT)) u_rd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req        (rd_req),
        .adr        (BASE_ADDR + rd_off),
        .done       (rd_done),
        .err        (rd_err),
        .tout       (rd_tout),
        .rdata      (rd_data),
        .wb_cyc_o   (bus.wb_cyc_o),
        .wb_stb_o   (bus.wb_stb_o),
        .wb_adr_o   (bus.wb_adr_o),
        .wb_dat_i   (bus.wb_dat_i),
        .wb_ack_i   (bus.wb_ack_i),
        .wb_err_i   (bus.wb_err_i),
        .wb_stall_i (bus.wb_stall_i)
    );

    assign bus.wb_sel_o    = '1;
    assign bus.wb_we_o     = 1'b0;
    assign bus.wb_dat_o    = '0;
    assign bus.ts_valid_o  = (state_q == ST_DELIVER);
    assign bus.ts_sec_o    = {sec_hi, sec_lo};
    assign bus.ts_cycles_o = cycles;
    assign bus.ts_mask_o   = mask;
    assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_WAIT_POLL);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus request; reads before the pop stop at enable loss,
    // the cycles read always runs through to delivery.
    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        rd_off  = OFF_STATUS;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RD_STATUS;
            end
            ST_RD_STATUS: begin
                rd_req = 1'b1;
                rd_off = OFF_STATUS;
                if (rd_err || rd_tout)            state_d = ST_WAIT_POLL;
                else if (rd_done && !enable_i)    state_d = ST_IDLE;
                else if (rd_done)                 state_d = rd_data[TS_PRESENT] ? ST_RD_HI : ST_WAIT_POLL;
            end
            ST_WAIT_POLL: begin
                if (!enable_i)                                   state_d = ST_IDLE;
                else if (poll_cnt == 16'(POLL_INTERVAL - 1))     state_d = ST_RD_STATUS;
            end
            ST_RD_HI: begin
                rd_req = 1'b1;
                rd_off = OFF_TS_HI;
                if (rd_err || rd_tout) state_d = ST_WAIT_POLL;
                else if (rd_done)      state_d = enable_i ? ST_RD_LO : ST_IDLE;
            end
            ST_RD_LO: begin
                rd_req = 1'b1;
                rd_off = OFF_TS_LO;
                if (rd_err || rd_tout) state_d = ST_WAIT_POLL;
                else if (rd_done)      state_d = enable_i ? ST_RD_CYC : ST_IDLE;
            end
            ST_RD_CYC: begin
                rd_req = 1'b1;
                rd_off = OFF_TS_CYCLES;
                if (rd_err || rd_tout) state_d = ST_WAIT_POLL;
                else if (rd_done)      state_d = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (bus.ts_ready_i) state_d = enable_i ? ST_RD_STATUS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Idle-cycle counter for the poll interval.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != ST_WAIT_POLL) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end

    // Timestamp fields, delivery counter and sticky fault flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_hi     <= '0;
            sec_lo     <= '0;
            cycles     <= '0;
            mask       <= '0;
            ts_count_o <= '0;
            bus_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            if (rd_done) begin
                case (state_q)
                    ST_RD_HI: begin
                        sec_hi <= rd_data[7:0];
                        mask   <= {rd_data[MASK_EXT_BIT], rd_data[MASK_CH4_BIT],
                                   rd_data[MASK_CH3_BIT], rd_data[MASK_CH2_BIT],
                                   rd_data[MASK_CH1_BIT]};
                    end
                    ST_RD_LO:  sec_lo <= rd_data;
                    ST_RD_CYC: cycles <= rd_data[27:0];
                    default: ;
                endcase
            end
            if (state_q == ST_DELIVER && bus.ts_ready_i) begin
                ts_count_o <= ts_count_o + 16'd1;
            end
            if (rd_err)  bus_err_o <= 1'b1;
            if (rd_tout) timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alt_trigout_reader.sv
// Scoreboard bench: slave register-bank model, stream monitor, directed tests.
module tb_alt_trigout_reader;

    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int P  = 16;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] ts_count;
    logic        bus_err;
    logic        tmo;
    logic        busy;

    alt_trigout_reader_if bus ();

    alt_trigout_reader #(
        .BASE_ADDR     (BASE),
        .POLL_INTERVAL (P),
        .TIMEOUT       (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .bus        (bus.master),
        .ts_count_o (ts_count),
        .bus_err_o  (bus_err),
        .timeout_o  (tmo),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct { logic [31:0] hi; logic [31:0] lo; logic [31:0] cy; } entry_t;
    typedef struct { logic [39:0] sec; logic [4:0] mask; logic [27:0] cy; } exp_t;

    entry_t      slv_q[$];
    exp_t        sb_q[$];
    logic [31:0] log_adr[$];
    int          log_t[$];

    int          stall_n = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_off = '0;
    bit          noack_next = 1'b0;
    int          stb_drop_viol = 0;
    int          deliver_viol = 0;
    int          first_valid_t = -1;
    int          dlv = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] cy,
                        input logic [39:0] esec, input logic [4:0] emask, input logic [27:0] ecy);
        entry_t e;
        exp_t   x;
        e.hi = hi; e.lo = lo; e.cy = cy;
        x.sec = esec; x.mask = emask; x.cy = ecy;
        slv_q.push_back(e);
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_t.delete();
    endtask

    task automatic wait_log(input int n, input int bound, input string name);
        int i = 0;
        while (log_adr.size() < n && i < bound) begin tick(); i++; end
        if (log_adr.size() < n) fail_now(name);
    endtask

    task automatic wait_count(input logic [15:0] n, input int bound, input string name);
        int i = 0;
        while (ts_count != n && i < bound) begin tick(); i++; end
        if (ts_count != n) fail_now(name);
    endtask

    task automatic wait_stb(input logic [31:0] off, input int bound, input string name);
        int i = 0;
        while (!(bus.wb_stb_o && bus.wb_adr_o == BASE + off) && i < bound) begin tick(); i++; end
        if (!(bus.wb_stb_o && bus.wb_adr_o == BASE + off)) fail_now(name);
    endtask

    task automatic stop_engine(input string name);
        int i = 0;
        enable = 1'b0;
        tick();
        while ((busy || bus.wb_cyc_o) && i < 200) begin tick(); i++; end
        if (busy || bus.wb_cyc_o) fail_now(name);
    endtask

    // Register-bank slave: stall, one-shot err, one-shot missing ack, FIFO pop on cycles read.
    initial begin
        bit          in_req;
        bit          pend;
        bit          pend_noack;
        int          stall_left;
        logic [31:0] pend_adr;
        logic [31:0] off;
        in_req = 0; pend = 0; pend_noack = 0; stall_left = 0; pend_adr = '0;
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_stall_i = 1'b0; bus.wb_dat_i = '0;
        forever begin
            tick();
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_dat_i = '0;
            if (pend && bus.wb_cyc_o && !pend_noack) begin
                off = pend_adr - BASE;
                if (err_en && off == err_off) begin
                    err_en = 1'b0;
                    bus.wb_err_i = 1'b1;
                end else begin
                    bus.wb_ack_i = 1'b1;
                    case (off)
                        32'h00: bus.wb_dat_i = (slv_q.size() > 0) ? 32'h0000_0100 : 32'h0;
                        32'h08: bus.wb_dat_i = (slv_q.size() > 0) ? slv_q[0].hi : 32'h0;
                        32'h0C: bus.wb_dat_i = (slv_q.size() > 0) ? slv_q[0].lo : 32'h0;
                        32'h10: if (slv_q.size() > 0) begin
                                    bus.wb_dat_i = slv_q[0].cy;
                                    void'(slv_q.pop_front());
                                end
                        default: bus.wb_dat_i = 32'h0;
                    endcase
                end
            end
            pend = 0;
            if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (!in_req) begin in_req = 1; stall_left = stall_n; end
                if (stall_left > 0) begin
                    bus.wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    bus.wb_stall_i = 1'b0;
                    in_req = 0;
                    pend = 1;
                    pend_adr = bus.wb_adr_o;
                    pend_noack = noack_next;
                    noack_next = 1'b0;
                    log_adr.push_back(bus.wb_adr_o - BASE);
                    log_t.push_back(cyc_n);
                end
            end else begin
                if (in_req && !rst) stb_drop_viol++;
                in_req = 0;
                bus.wb_stall_i = 1'b0;
            end
        end
    end

    // Stream monitor: pops the scoreboard on each handshake.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && bus.ts_valid_o && first_valid_t < 0) first_valid_t = cyc_n;
            if (!rst && bus.ts_valid_o && !bus.ts_ready_i && bus.wb_cyc_o) deliver_viol++;
            if (!rst && bus.ts_valid_o && bus.ts_ready_i) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_delivery");
                end else begin
                    x = sb_q.pop_front();
                    chk("ts_sec",    64'(bus.ts_sec_o),    64'(x.sec));
                    chk("ts_mask",   64'(bus.ts_mask_o),   64'(x.mask));
                    chk("ts_cycles", 64'(bus.ts_cycles_o), 64'(x.cy));
                    chk("ts_count",  64'(ts_count),        64'(dlv));
                end
                dlv++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0;
        int a;
        int n10;
        rst = 1'b1;
        enable = 1'b0;
        bus.ts_ready_i = 1'b0;
        repeat (3) tick();

        chk("rst_cyc",     64'(bus.wb_cyc_o),    64'(0));
        chk("rst_stb",     64'(bus.wb_stb_o),    64'(0));
        chk("rst_adr",     64'(bus.wb_adr_o),    64'(0));
        chk("rst_sel",     64'(bus.wb_sel_o),    64'(4'hF));
        chk("rst_we",      64'(bus.wb_we_o),     64'(0));
        chk("rst_dat_o",   64'(bus.wb_dat_o),    64'(0));
        chk("rst_valid",   64'(bus.ts_valid_o),  64'(0));
        chk("rst_sec",     64'(bus.ts_sec_o),    64'(0));
        chk("rst_cycles",  64'(bus.ts_cycles_o), 64'(0));
        chk("rst_mask",    64'(bus.ts_mask_o),   64'(0));
        chk("rst_count",   64'(ts_count),        64'(0));
        chk("rst_bus_err", 64'(bus_err),         64'(0));
        chk("rst_timeout", 64'(tmo),             64'(0));
        chk("rst_busy",    64'(busy),            64'(0));
        rst = 1'b0;
        tick();

        // Empty FIFO: status polls spaced by the poll interval plus handshake.
        clear_log();
        enable = 1'b1;
        wait_log(3, 300, "t1_three_polls");
        stop_engine("t1_stop");
        chk("t1_adr0", 64'(log_adr[0]), 64'(0));
        chk("t1_adr1", 64'(log_adr[1]), 64'(0));
        chk("t1_adr2", 64'(log_adr[2]), 64'(0));
        chk("t1_gap01", 64'(log_t[1] - log_t[0]), 64'(P + 3));
        chk("t1_gap12", 64'(log_t[2] - log_t[1]), 64'(P + 3));
        chk("t1_no_valid", 64'(first_valid_t < 0), 64'(1));

        // Single entry, address order.
        clear_log();
        push(32'h0105_0012, 32'hDEAD_BEEF, 32'h0ABC_DEF1, 40'h12_DEAD_BEEF, 5'b10101, 28'hABC_DEF1);
        bus.ts_ready_i = 1'b1;
        enable = 1'b1;
        wait_count(16'd1, 300, "t2_delivery");
        stop_engine("t2_stop");
        chk("t2_adr0", 64'(log_adr[0]), 64'(32'h00));
        chk("t2_adr1", 64'(log_adr[1]), 64'(32'h08));
        chk("t2_adr2", 64'(log_adr[2]), 64'(32'h0C));
        chk("t2_adr3", 64'(log_adr[3]), 64'(32'h10));
        chk("t2_count", 64'(ts_count), 64'(1));

        // Stalling slave and a slow consumer.
        stall_n = 5;
        bus.ts_ready_i = 1'b0;
        clear_log();
        push(32'h0000_00FF, 32'h0000_0001, 32'hF000_0005, 40'hFF_0000_0001, 5'b00000, 28'h000_0005);
        enable = 1'b1;
        begin
            int i = 0;
            while (!bus.ts_valid_o && i < 400) begin tick(); i++; end
            if (!bus.ts_valid_o) fail_now("t3_valid");
        end
        n0 = log_adr.size();
        repeat (20) tick();
        chk("t3_no_bus_in_deliver", 64'(log_adr.size()), 64'(n0));
        chk("t3_valid_held", 64'(bus.ts_valid_o), 64'(1));
        bus.ts_ready_i = 1'b1;
        wait_count(16'd2, 100, "t3_delivery");
        stop_engine("t3_stop");
        chk("t3_stb_held_in_stall", 64'(stb_drop_viol), 64'(0));
        n10 = 0;
        foreach (log_adr[k]) if (log_adr[k] == 32'h10) n10++;
        chk("t3_one_cycles_read", 64'(n10), 64'(1));
        stall_n = 0;

        // Three queued entries drained back-to-back.
        clear_log();
        push(32'h0008_0001, 32'h1234_5678, 32'h0000_0010, 40'h01_1234_5678, 5'b01000, 28'h000_0010);
        push(32'h0100_0080, 32'h8765_4321, 32'h0FFF_FFFF, 40'h80_8765_4321, 5'b10000, 28'hFFF_FFFF);
        push(32'hFE0F_FF7F, 32'hFFFF_FFFF, 32'h0000_0000, 40'h7F_FFFF_FFFF, 5'b01111, 28'h000_0000);
        enable = 1'b1;
        wait_log(14, 400, "t4_drain");
        stop_engine("t4_stop");
        for (int k = 0; k < 12; k++) begin
            logic [31:0] want;
            case (k % 4)
                0: want = 32'h00;
                1: want = 32'h08;
                2: want = 32'h0C;
                default: want = 32'h10;
            endcase
            chk("t4_adr", 64'(log_adr[k]), 64'(want));
        end
        chk("t4_adr12", 64'(log_adr[12]), 64'(0));
        chk("t4_adr13", 64'(log_adr[13]), 64'(0));
        chk("t4_gap_e1", 64'(log_t[4]  - log_t[3]),  64'(4));
        chk("t4_gap_e2", 64'(log_t[8]  - log_t[7]),  64'(4));
        chk("t4_gap_e3", 64'(log_t[12] - log_t[11]), 64'(4));
        chk("t4_gap_poll", 64'(log_t[13] - log_t[12]), 64'(P + 3));
        chk("t4_count", 64'(ts_count), 64'(5));

        // Err on the lo read: partial entry dropped, re-read after the poll wait.
        clear_log();
        first_valid_t = -1;
        push(32'h0102_0033, 32'hCAFE_F00D, 32'h0123_4567, 40'h33_CAFE_F00D, 5'b10010, 28'h123_4567);
        err_off = 32'h0C;
        err_en = 1'b1;
        enable = 1'b1;
        wait_count(16'd6, 400, "t5_delivery");
        stop_engine("t5_stop");
        chk("t5_bus_err", 64'(bus_err), 64'(1));
        chk("t5_err_adr", 64'(log_adr[2]), 64'(32'h0C));
        chk("t5_next_status", 64'(log_adr[3]), 64'(0));
        chk("t5_gap", 64'(log_t[3] - log_t[2]), 64'(P + 3));
        chk("t5_no_early_valid", 64'(first_valid_t > log_t[3]), 64'(1));

        // Slave that never acks.
        clear_log();
        noack_next = 1'b1;
        enable = 1'b1;
        wait_log(1, 100, "t6_accept");
        a = log_t[0];
        begin
            int i = 0;
            while (cyc_n < a + TO && i < 200) begin tick(); i++; end
        end
        chk("t6_cyc_before_to", 64'(bus.wb_cyc_o), 64'(1));
        chk("t6_flag_before_to", 64'(tmo), 64'(0));
        tick();
        chk("t6_cyc_dropped", 64'(bus.wb_cyc_o), 64'(0));
        chk("t6_timeout", 64'(tmo), 64'(1));
        stop_engine("t6_stop");

        // enable dropped during the hi read.
        clear_log();
        stall_n = 3;
        push(32'h0004_0044, 32'h0BAD_CAFE, 32'h0765_4321, 40'h44_0BAD_CAFE, 5'b00100, 28'h765_4321);
        enable = 1'b1;
        wait_stb(32'h08, 200, "t7_hi_stb");
        stop_engine("t7_stop");
        repeat (2 * P) tick();
        chk("t7_reads", 64'(log_adr.size()), 64'(2));
        chk("t7_last_hi", 64'(log_adr[1]), 64'(32'h08));
        chk("t7_busy", 64'(busy), 64'(0));
        chk("t7_no_valid", 64'(bus.ts_valid_o), 64'(0));

        // Entry left in the FIFO is read again later.
        stall_n = 0;
        enable = 1'b1;
        wait_count(16'd7, 300, "t8_redelivery");
        stop_engine("t8_stop");

        // Reset in the middle of the cycles read.
        slv_q.push_back('{hi: 32'h0101_0055, lo: 32'h1111_2222, cy: 32'h0333_4444});
        stall_n = 3;
        enable = 1'b1;
        wait_stb(32'h10, 200, "t9_cyc_stb");
        chk("t9_count_before", 64'(ts_count), 64'(7));
        rst = 1'b1;
        tick();
        chk("t9_cyc",     64'(bus.wb_cyc_o),    64'(0));
        chk("t9_stb",     64'(bus.wb_stb_o),    64'(0));
        chk("t9_adr",     64'(bus.wb_adr_o),    64'(0));
        chk("t9_sec",     64'(bus.ts_sec_o),    64'(0));
        chk("t9_mask",    64'(bus.ts_mask_o),   64'(0));
        chk("t9_cycles",  64'(bus.ts_cycles_o), 64'(0));
        chk("t9_count",   64'(ts_count),        64'(0));
        chk("t9_bus_err", 64'(bus_err),         64'(0));
        chk("t9_timeout", 64'(tmo),             64'(0));
        chk("t9_busy",    64'(busy),            64'(0));
        enable = 1'b0;
        tick();
        rst = 1'b0;
        slv_q.delete();
        dlv = 0;
        stall_n = 0;
        repeat (3) tick();

        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        chk("deliver_bus_quiet", 64'(deliver_viol), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
